// File: rtl/fp_norm_pkg.sv
// fp_norm_pkg: shared widths, case encoding and stage-1 control payload for the normalizer
package fp_norm_pkg;
  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 24;
  function automatic int exp_max(input int w);
    return (1 << w) - 1;
  endfunction
  localparam int EXP_MAX = exp_max(FP_EXP_W);
  typedef enum logic [1:0] {NC_CARRY, NC_ZERO, NC_NORMAL, NC_UNDERFLOW} norm_case_t;
  typedef struct packed {
    norm_case_t nc;
    logic ovf;
    logic sticky;
  } norm_ctl_t;
endpackage

// File: rtl/lzc.sv
// lzc: combinational leading-zero counter with all-zero flag
module lzc #(
  parameter int W = 24,
  localparam int CW = $clog2(W + 1)
) (
  input logic [W-1:0] a,
  output logic [CW-1:0] cnt,
  output logic zero
);
  always_comb begin
    cnt = CW'(W);
    for (int i = 0; i < W; i++) if (a[i]) cnt = CW'(W - 1 - i);
  end
  assign zero = ~|a;
endmodule

// File: rtl/fp_normalizer_pipe.sv
// fp_normalizer_pipe: pipelined post-addition normalizer with valid/ready handshake
module fp_normalizer_pipe
  import fp_norm_pkg::*;
#(
  parameter int EXP_W = FP_EXP_W,
  parameter int MAN_W = FP_MAN_W,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W = 4
) (
  input logic clk,
  input logic rst,
  input logic in_valid,
  output logic in_ready,
  input logic [EXP_W-1:0] in_e,
  input logic [MAN_W:0] in_m,
  input logic [TAG_W-1:0] in_tag,
  output logic out_valid,
  input logic out_ready,
  output logic [EXP_W-1:0] out_e,
  output logic [MAN_W-1:0] out_m,
  output logic out_sticky,
  output logic out_zero,
  output logic out_denorm,
  output logic out_ovf,
  output logic [TAG_W-1:0] out_tag
);
  localparam int LW = $clog2(MAN_W + 1);
  localparam logic [EXP_W:0] EMAX = (EXP_W + 1)'(exp_max(EXP_W));
  logic [LW-1:0] lz, sh_d, sh_q;
  logic lz_zero, carry, ovf, v_q, ld_out;
  logic [EXP_W:0] e_inc;
  logic [EXP_W-1:0] e_sub, e_d, e_q;
  logic [MAN_W-1:0] m_d, m_q;
  logic [TAG_W-1:0] tag_q;
  norm_case_t nc;
  norm_ctl_t ctl_d, ctl_q;
  lzc #(.W(MAN_W)) u_lzc (.a(in_m[MAN_W-1:0]), .cnt(lz), .zero(lz_zero));
  assign carry = in_m[MAN_W];
  assign e_inc = (EXP_W + 1)'(in_e) + (EXP_W + 1)'(1);
  assign e_sub = in_e - EXP_W'(lz);
  assign ovf = carry && e_inc >= EMAX;
  assign nc = carry ? NC_CARRY : lz_zero ? NC_ZERO :
              (EXP_W + 1)'(in_e) > (EXP_W + 1)'(lz) ? NC_NORMAL : NC_UNDERFLOW;
  assign ctl_d = '{nc: nc, ovf: ovf, sticky: carry && !ovf && in_m[0]};
  assign e_d = ovf ? '1 : carry ? e_inc[EXP_W-1:0] : nc == NC_NORMAL ? e_sub : '0;
  assign m_d = ovf ? '0 : carry ? in_m[MAN_W:1] : in_m[MAN_W-1:0];
  assign sh_d = nc == NC_NORMAL ? lz :
                nc == NC_UNDERFLOW && in_e != '0 ? LW'(in_e - EXP_W'(1)) : '0;
  assign ld_out = !out_valid || out_ready;
  generate
    if (PIPE_STAGES == 2) begin : g_two
      always_ff @(posedge clk) begin
        if (rst) begin
          v_q <= 1'b0;
        end else if (in_ready) begin
          v_q <= in_valid;
          if (in_valid) begin
            ctl_q <= ctl_d;
            e_q <= e_d;
            m_q <= m_d;
            sh_q <= sh_d;
            tag_q <= in_tag;
          end
        end
      end
      assign in_ready = !v_q || ld_out;
    end else begin : g_one
      assign v_q = in_valid;
      assign ctl_q = ctl_d;
      assign e_q = e_d;
      assign m_q = m_d;
      assign sh_q = sh_d;
      assign tag_q = in_tag;
      assign in_ready = ld_out;
    end
  endgenerate
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_e <= '0;
      out_m <= '0;
      out_sticky <= 1'b0;
      out_zero <= 1'b0;
      out_denorm <= 1'b0;
      out_ovf <= 1'b0;
      out_tag <= '0;
    end else if (ld_out) begin
      out_valid <= v_q;
      if (v_q) begin
        out_e <= e_q;
        out_m <= m_q << sh_q;
        out_sticky <= ctl_q.sticky;
        out_zero <= ctl_q.nc == NC_ZERO;
        out_denorm <= ctl_q.nc == NC_UNDERFLOW;
        out_ovf <= ctl_q.ovf;
        out_tag <= tag_q;
      end
    end
  end
endmodule

// File: tb/tb_fp_normalizer_pipe.sv
// tb_fp_normalizer_pipe: directed vectors checked against a behavioural normalizer model
module tb_fp_normalizer_pipe;
  typedef logic [39:0] beat_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [7:0] in_e = '0;
  logic [24:0] in_m = '0;
  logic [3:0] in_tag = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [7:0] out_e;
  logic [23:0] out_m;
  logic out_sticky, out_zero, out_denorm, out_ovf;
  logic [3:0] out_tag;
  int total = 0;
  int bad = 0;
  int stalled = 0;
  int cyc = 0;
  beat_t q[$];
  logic [3:0] got[$];
  fp_normalizer_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_e(in_e), .in_m(in_m), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_e(out_e), .out_m(out_m), .out_sticky(out_sticky), .out_zero(out_zero),
    .out_denorm(out_denorm), .out_ovf(out_ovf), .out_tag(out_tag)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  function automatic beat_t model(input int e, input int m, input int tag);
    int lz, sh, p;
    logic [7:0] oe;
    logic [23:0] om;
    logic s, z, d, o;
    {oe, om, s, z, d, o} = '0;
    p = 0;
    if (m >= 'h1000000) begin
      if (e + 1 >= 255) begin
        oe = 8'd255;
        o = 1'b1;
      end else begin
        oe = 8'(e + 1);
        om = 24'(m / 2);
        s = (m % 2) == 1;
      end
    end else if (m == 0) begin
      z = 1'b1;
    end else begin
      for (int i = 0; i < 24; i++) if (((m >> i) & 1) == 1) p = i;
      lz = 23 - p;
      if (e > lz) begin
        om = 24'(m << lz);
        oe = 8'(e - lz);
      end else begin
        sh = (e == 0) ? 0 : e - 1;
        om = 24'(m << sh);
        d = 1'b1;
      end
    end
    return {oe, om, s, z, d, o, 4'(tag)};
  endfunction
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      check("in_ready", in_ready, !(q.size() >= 2 && !out_ready));
      if (!in_ready) stalled++;
      if (out_valid) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: out_valid=1 tag=%0d want no beat", out_tag);
        end else begin
          check("beat", {out_e, out_m, out_sticky, out_zero, out_denorm, out_ovf, out_tag}, q[0]);
          if (out_ready) begin
            got.push_back(out_tag);
            void'(q.pop_front());
          end
        end
      end
      if (in_valid && in_ready) q.push_back(model(int'(in_e), int'(in_m), int'(in_tag)));
    end
  end
  task automatic send(input int e, input int m, input int t);
    int n;
    logic ok;
    n = 0;
    in_e = 8'(e);
    in_m = 25'(m);
    in_tag = 4'(t);
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 50);
    in_valid = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send_timeout: tag=%0d in_ready stayed 0 want 1", t);
    end
  endtask
  task automatic drain();
    for (int i = 0; i < 50 && q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check("drain", q.size(), 0);
  endtask
  int ve[12] = '{100, 100, 100, 254, 55, 5, 0, 1, 2, 253, 255, 0};
  int vm[12] = '{'h0800000, 'h1, 'h1800001, 'h1000000, 0, 'h10,
                 'h0400000, 'h0400000, 'h0400000, 'h1000001, 'h1FFFFFF, 0};
  beat_t vx[12] = '{
    {8'd100, 24'h800000, 4'b0000, 4'd0},
    {8'd77,  24'h800000, 4'b0000, 4'd1},
    {8'd101, 24'hC00000, 4'b1000, 4'd2},
    {8'd255, 24'h000000, 4'b0001, 4'd3},
    {8'd0,   24'h000000, 4'b0100, 4'd4},
    {8'd0,   24'h000100, 4'b0010, 4'd5},
    {8'd0,   24'h400000, 4'b0010, 4'd6},
    {8'd0,   24'h400000, 4'b0010, 4'd7},
    {8'd1,   24'h800000, 4'b0000, 4'd8},
    {8'd254, 24'h800000, 4'b1000, 4'd9},
    {8'd255, 24'h000000, 4'b0001, 4'd10},
    {8'd0,   24'h000000, 4'b0100, 4'd11}
  };
  initial begin
    int t0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_data", {out_e, out_m, out_sticky, out_zero, out_denorm, out_ovf, out_tag}, 0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) check($sformatf("pin%0d", i), model(ve[i], vm[i], i), vx[i]);
    send(ve[0], vm[0], 0);
    check("lat_cycle1", out_valid, 0);
    @(posedge clk);
    #1;
    check("lat_cycle2", out_valid, 1);
    drain();
    t0 = cyc;
    for (int i = 1; i < 12; i++) send(ve[i], vm[i], i);
    check("throughput", cyc - t0, 11);
    drain();
    got.delete();
    stalled = 0;
    fork
      for (int c = 0; c < 14; c++) begin
        out_ready = (c < 3 || c > 7);
        @(posedge clk);
        #1;
      end
      for (int i = 0; i < 6; i++) send(100 + i, 'h10000 << i, i);
    join
    out_ready = 1'b1;
    drain();
    check("stall_seen", stalled > 0, 1);
    check("tag_count", got.size(), 6);
    for (int i = 0; i < 6; i++) check($sformatf("tag_order%0d", i), got[i], i);
    out_ready = 1'b0;
    send(20, 'h0123456, 12);
    send(30, 'h1000003, 13);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_valid", out_valid, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
      check("no_stale", out_valid, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
